// File: rtl/vdp_write_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vdp_write_ctrl : host FIFO + block-fill engine arbitrated onto VDP write    |
// | port. Fill engine/arbiter built only when VDP_FILL_EN is defined. Rev 1.0   |
// +----------------------------------------------------------------------------+
module vdp_write_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3
) (
  input  logic             write_clk,
  input  logic             reset_n,
  input  logic             host_valid,
  output logic             host_ready,
  input  logic [13:0]      host_addr,
  input  logic [7:0]       host_data,
  input  logic             fill_start,
  input  logic [13:0]      fill_base,
  input  logic [14:0]      fill_count,
  input  logic [7:0]       fill_value,
  output logic             fill_busy,
  output logic             fill_done,
  output logic [LVL_W-1:0] fifo_level,
  output logic [13:0]      vdp_addr,
  output logic [7:0]       vdp_data,
  output logic             vdp_we
);

  localparam int               PTR_W    = LVL_W - 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  logic [13:0]      mem_addr_q [FIFO_DEPTH];
  logic [7:0]       mem_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_q, push_d;
  logic             push, pop, host_elig;
  logic             grant_host, grant_fill;
  logic [13:0]      fill_wr_addr;
  logic [7:0]       fill_wr_data;
  logic             vdp_we_q, vdp_we_d;
  logic [13:0]      vdp_addr_q, vdp_addr_d;
  logic [7:0]       vdp_data_q, vdp_data_d;

  assign host_ready = (level_q != FULL_LVL);
  assign push       = host_valid & host_ready;
  assign pop        = grant_host;
  // An entry pushed on the previous edge is not yet eligible, so a lone new
  // entry waits one cycle; older entries ahead of it are served at once.
  assign host_elig  = (level_q > {{(LVL_W-1){1'b0}}, push_q});

  always_comb begin
    wr_ptr_d = wr_ptr_q + (push ? PTR_W'(1) : PTR_W'(0));
    rd_ptr_d = rd_ptr_q + (pop  ? PTR_W'(1) : PTR_W'(0));
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    push_d   = push;
  end

  always_ff @(posedge write_clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= host_addr;
      mem_data_q[wr_ptr_q] <= host_data;
    end
  end

  always_ff @(posedge write_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      push_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      push_q   <= push_d;
    end
  end

`ifdef VDP_FILL_EN
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [13:0] faddr_q, faddr_d;
  logic [14:0] remain_q, remain_d;
  logic [7:0]  fvalue_q, fvalue_d;
  logic        last_fill_q, last_fill_d;
  logic        done_q, done_d;
  logic        fill_elig;

  assign fill_elig = (state_q == ST_RUN);

  // Round-robin: on contention the source not served last wins.
  always_comb begin
    grant_host = host_elig;
    grant_fill = fill_elig;
    if (host_elig && fill_elig) begin
      grant_host = last_fill_q;
      grant_fill = ~last_fill_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    faddr_d     = faddr_q;
    remain_d    = remain_q;
    fvalue_d    = fvalue_q;
    last_fill_d = last_fill_q;
    done_d      = (state_q == ST_DONE);
    if (grant_host) begin
      last_fill_d = 1'b0;
    end else if (grant_fill) begin
      last_fill_d = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          faddr_d  = fill_base;
          remain_d = fill_count;
          fvalue_d = fill_value;
          state_d  = (fill_count == 15'd0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (grant_fill) begin
          faddr_d  = faddr_q + 14'd1;
          remain_d = remain_q - 15'd1;
          if (remain_q == 15'd1) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge write_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      faddr_q     <= '0;
      remain_q    <= '0;
      fvalue_q    <= '0;
      last_fill_q <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      faddr_q     <= faddr_d;
      remain_q    <= remain_d;
      fvalue_q    <= fvalue_d;
      last_fill_q <= last_fill_d;
      done_q      <= done_d;
    end
  end

  assign fill_busy    = (state_q == ST_RUN);
  assign fill_done    = done_q;
  assign fill_wr_addr = faddr_q;
  assign fill_wr_data = fvalue_q;
`else
  logic unused_fill;

  assign unused_fill  = ^{fill_start, fill_base, fill_count, fill_value};
  assign grant_host   = host_elig;
  assign grant_fill   = 1'b0;
  assign fill_busy    = 1'b0;
  assign fill_done    = 1'b0;
  assign fill_wr_addr = '0;
  assign fill_wr_data = '0;
`endif

  always_comb begin
    vdp_we_d   = grant_host | grant_fill;
    vdp_addr_d = vdp_addr_q;
    vdp_data_d = vdp_data_q;
    if (grant_host) begin
      vdp_addr_d = mem_addr_q[rd_ptr_q];
      vdp_data_d = mem_data_q[rd_ptr_q];
    end else if (grant_fill) begin
      vdp_addr_d = fill_wr_addr;
      vdp_data_d = fill_wr_data;
    end
  end

  always_ff @(posedge write_clk or negedge reset_n) begin
    if (!reset_n) begin
      vdp_we_q   <= 1'b0;
      vdp_addr_q <= '0;
      vdp_data_q <= '0;
    end else begin
      vdp_we_q   <= vdp_we_d;
      vdp_addr_q <= vdp_addr_d;
      vdp_data_q <= vdp_data_d;
    end
  end

  assign vdp_we     = vdp_we_q;
  assign vdp_addr   = vdp_addr_q;
  assign vdp_data   = vdp_data_q;
  assign fifo_level = level_q;

endmodule
`default_nettype wire

// File: tb/tb_vdp_write_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vdp_write_ctrl : directed self-checking bench for vdp_write_ctrl.        |
// | Fill tests run when VDP_FILL_EN is defined. Rev 1.0                         |
// +----------------------------------------------------------------------------+
module tb_vdp_write_ctrl;

  logic        write_clk = 1'b0;
  logic        reset_n;
  logic        host_valid;
  logic        host_ready;
  logic [13:0] host_addr;
  logic [7:0]  host_data;
  logic        fill_start;
  logic [13:0] fill_base;
  logic [14:0] fill_count;
  logic [7:0]  fill_value;
  logic        fill_busy;
  logic        fill_done;
  logic [2:0]  fifo_level;
  logic [13:0] vdp_addr;
  logic [7:0]  vdp_data;
  logic        vdp_we;

  always #5 write_clk = ~write_clk;

  vdp_write_ctrl dut (
    .write_clk  (write_clk),
    .reset_n    (reset_n),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_addr  (host_addr),
    .host_data  (host_data),
    .fill_start (fill_start),
    .fill_base  (fill_base),
    .fill_count (fill_count),
    .fill_value (fill_value),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .fifo_level (fifo_level),
    .vdp_addr   (vdp_addr),
    .vdp_data   (vdp_data),
    .vdp_we     (vdp_we)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [21:0] wr_q[$];
  logic [21:0] exp_q[$];

  // Every write that reaches the port, as {addr, data}.
  always @(posedge write_clk) begin
    #1;
    if (vdp_we === 1'b1) wr_q.push_back({vdp_addr, vdp_data});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge write_clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic exp_wr(input logic [13:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
      chk({tag, "_wr"}, 32'(wr_q[i]), 32'(exp_q[i]));
    wr_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"},    32'(vdp_we),     0);
    chk({tag, "_addr"},  32'(vdp_addr),   0);
    chk({tag, "_data"},  32'(vdp_data),   0);
    chk({tag, "_ready"}, 32'(host_ready), 1);
    chk({tag, "_busy"},  32'(fill_busy),  0);
    chk({tag, "_done"},  32'(fill_done),  0);
    chk({tag, "_level"}, 32'(fifo_level), 0);
  endtask

  task automatic idle_inputs();
    host_valid = 1'b0;
    host_addr  = '0;
    host_data  = '0;
    fill_start = 1'b0;
    fill_base  = '0;
    fill_count = '0;
    fill_value = '0;
  endtask

  int idx;
  int acc;
  int acc_c[8];
  int exp_acc[8] = '{0, 1, 2, 3, 4, 5, 7, 9};
  int seen;

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    chk_reset_vals("rst");
    reset_n = 1'b1;
    tick();
    chk("rst_rel_ready", 32'(host_ready), 1);
    chk("rst_rel_level", 32'(fifo_level), 0);
    wr_q.delete();

    // Single host write: visible two edges after acceptance, for one cycle.
    host_valid = 1'b1; host_addr = 14'h2005; host_data = 8'hA5;
    tick();
    host_valid = 1'b0;
    chk("t1_level_k", 32'(fifo_level), 1);
    chk("t1_we_k", 32'(vdp_we), 0);
    tick();
    chk("t1_we_k1", 32'(vdp_we), 0);
    tick();
    chk("t1_we_k2", 32'(vdp_we), 1);
    chk("t1_addr", 32'(vdp_addr), 32'h2005);
    chk("t1_data", 32'(vdp_data), 32'hA5);
    chk("t1_level_k2", 32'(fifo_level), 0);
    tick();
    chk("t1_we_k3", 32'(vdp_we), 0);
    wr_q.delete();

`ifdef VDP_FILL_EN
    // Fill across the top of the address space.
    fill_start = 1'b1; fill_base = 14'h3FFE; fill_count = 15'd4; fill_value = 8'h00;
    tick();
    fill_start = 1'b0;
    chk("t2_busy", 32'(fill_busy), 1);
    chk("t2_we0", 32'(vdp_we), 0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("t2_we", 32'(vdp_we), 1);
      chk("t2_done_early", 32'(fill_done), 0);
    end
    tick();
    chk("t2_done", 32'(fill_done), 1);
    chk("t2_we_after", 32'(vdp_we), 0);
    chk("t2_busy_after", 32'(fill_busy), 0);
    tick();
    chk("t2_done_pulse", 32'(fill_done), 0);
    exp_wr(14'h3FFE, 8'h00); exp_wr(14'h3FFF, 8'h00);
    exp_wr(14'h0000, 8'h00); exp_wr(14'h0001, 8'h00);
    chk_stream("t2");

    // Zero-count fill: done pulse, no writes.
    fill_start = 1'b1; fill_base = 14'h0123; fill_count = 15'd0; fill_value = 8'hEE;
    tick();
    fill_start = 1'b0;
    chk("t3_busy", 32'(fill_busy), 0);
    chk("t3_we0", 32'(vdp_we), 0);
    tick();
    chk("t3_done", 32'(fill_done), 1);
    chk("t3_we1", 32'(vdp_we), 0);
    tick();
    chk("t3_done_pulse", 32'(fill_done), 0);
    exp_q.delete();
    chk_stream("t3");

    // Contention: 8 fill bytes and 4 host writes started together.
    for (int c = 0; c < 14; c++) begin
      host_valid = (c < 4);
      host_addr  = 14'h1000 + 14'(c);
      host_data  = 8'h10 + 8'(c);
      fill_start = (c == 0);
      fill_base  = 14'h0100; fill_count = 15'd8; fill_value = 8'h5A;
      tick();
      chk("t4_done", 32'(fill_done), 32'(c == 13));
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      exp_wr(14'h0100 + 14'(i), 8'h5A);
      exp_wr(14'h1000 + 14'(i), 8'h10 + 8'(i));
    end
    for (int i = 4; i < 8; i++) exp_wr(14'h0100 + 14'(i), 8'h5A);
    chk_stream("t4");

    // FIFO fills under alternation; a second fill_start during RUN is ignored.
    idx = 0;
    for (int c = 0; c < 28; c++) begin
      host_valid = (idx < 8);
      host_addr  = 14'h2100 + 14'(idx);
      host_data  = 8'h80 + 8'(idx);
      fill_start = (c == 0) || (c == 3);
      fill_base  = (c == 0) ? 14'h0200 : 14'h3000;
      fill_count = (c == 0) ? 15'd16 : 15'd5;
      fill_value = (c == 0) ? 8'hC3 : 8'hFF;
      acc = (host_valid && host_ready) ? 1 : 0;
      tick();
      if (acc == 1) begin
        acc_c[idx] = c;
        idx++;
      end
      if (fifo_level == 3'd4) chk("t5_ready_full", 32'(host_ready), 0);
      if (c == 5) chk("t5_level_e5", 32'(fifo_level), 4);
      chk("t5_done", 32'(fill_done), 32'(c == 25));
    end
    idle_inputs();
    chk("t5_accepted", 32'(idx), 8);
    for (int i = 0; i < 8; i++) chk("t5_acc_cycle", 32'(acc_c[i]), 32'(exp_acc[i]));
    for (int i = 0; i < 8; i++) begin
      exp_wr(14'h0200 + 14'(i), 8'hC3);
      exp_wr(14'h2100 + 14'(i), 8'h80 + 8'(i));
    end
    for (int i = 8; i < 16; i++) exp_wr(14'h0200 + 14'(i), 8'hC3);
    chk_stream("t5");

    // Reset mid-fill with a host entry still queued.
    for (int c = 0; c < 4; c++) begin
      host_valid = (c < 2);
      host_addr  = 14'h3100 + 14'(c);
      host_data  = 8'h40 + 8'(c);
      fill_start = (c == 0);
      fill_base  = 14'h0300; fill_count = 15'd10; fill_value = 8'h77;
      tick();
    end
    idle_inputs();
    chk("t6_level_pre", 32'(fifo_level), 1);
    chk("t6_busy_pre", 32'(fill_busy), 1);
    chk("t6_we_pre", 32'(vdp_we), 1);
`else
    // Fill requests have no effect without the fill engine.
    fill_start = 1'b1; fill_base = 14'h0400; fill_count = 15'd4; fill_value = 8'h11;
    for (int c = 0; c < 6; c++) begin
      tick();
      fill_start = 1'b0;
      chk("d2_busy", 32'(fill_busy), 0);
      chk("d2_done", 32'(fill_done), 0);
    end
    exp_q.delete();
    chk_stream("d2");

    // Back-to-back host writes stream out on consecutive cycles.
    for (int c = 0; c < 8; c++) begin
      host_valid = (c < 4);
      host_addr  = 14'h1000 + 14'(c);
      host_data  = 8'h10 + 8'(c);
      fill_start = (c == 0); fill_count = 15'd3;
      tick();
      chk("d3_we", 32'(vdp_we), 32'(c >= 2 && c <= 5));
      chk("d3_done", 32'(fill_done), 0);
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) exp_wr(14'h1000 + 14'(i), 8'h10 + 8'(i));
    chk_stream("d3");

    // Reset with host entries still queued.
    for (int c = 0; c < 3; c++) begin
      host_valid = 1'b1;
      host_addr  = 14'h3100 + 14'(c);
      host_data  = 8'h40 + 8'(c);
      tick();
    end
    idle_inputs();
    chk("t6_level_pre", 32'(fifo_level), 2);
    chk("t6_we_pre", 32'(vdp_we), 1);
`endif

    reset_n = 1'b0;
    #1;
    chk_reset_vals("t6_async");
    tick();
    reset_n = 1'b1;
    wr_q.delete();
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (fill_done === 1'b1) seen++;
    end
    chk("t6_no_done", 32'(seen), 0);
    exp_q.delete();
    chk_stream("t6");
    chk("t6_level_post", 32'(fifo_level), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
